// File: rtl/axis_data_fifo_if.sv
// AXI4-Stream beat channel (valid/ready/data/last) shared by both FIFO sides.
interface axis_data_fifo_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_data_fifo.sv
// Single-clock first-word-fall-through AXI4-Stream FIFO for {tlast, tdata} beats.
// Storage is a synchronous-read RAM. The output beat comes either from the RAM
// read register or from a bypass register that catches a beat arriving while
// the RAM side is empty, which keeps the empty-to-valid latency at one cycle.
module axis_data_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                   s_axis_aclk,
  input  logic                   s_axis_areset,
  axis_data_fifo_if.slave        s_axis,
  axis_data_fifo_if.master       m_axis,
  output logic [$clog2(DEPTH):0] axis_data_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = DATA_WIDTH + 1;

  logic [BW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic [CW-1:0] ram_count;
  logic          ready_q;
  logic          out_valid;
  logic          out_valid_n;
  logic          out_sel;
  logic          out_sel_n;
  logic [BW-1:0] ram_q;
  logic [BW-1:0] byp_q;
  logic          push;
  logic          pop;
  logic          load;
  logic          ram_rd_en;
  logic          byp_en;
  logic          ram_we;

  // Handshake decode, output-stage refill choice and next occupancy.
  always_comb begin
    push        = s_axis.tvalid & ready_q;
    pop         = out_valid & m_axis.tready;
    ram_count   = count - CW'(out_valid);
    load        = ~out_valid | pop;
    ram_rd_en   = 1'b0;
    byp_en      = 1'b0;
    out_sel_n   = out_sel;
    out_valid_n = out_valid;
    if (load) begin
      if (ram_count != '0) begin
        ram_rd_en   = 1'b1;
        out_sel_n   = 1'b0;
        out_valid_n = 1'b1;
      end else if (push) begin
        byp_en      = 1'b1;
        out_sel_n   = 1'b1;
        out_valid_n = 1'b1;
      end else begin
        out_valid_n = 1'b0;
      end
    end
    // A beat that goes straight to the output stage never enters the RAM.
    ram_we  = push & ~byp_en;
    count_n = count + CW'(push) - CW'(pop);
  end

  // Pointers, occupancy, registered ready and output-stage control.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ready_q   <= 1'b0;
      out_valid <= 1'b0;
      out_sel   <= 1'b0;
    end else begin
      count     <= count_n;
      ready_q   <= (count_n != CW'(DEPTH));
      out_valid <= out_valid_n;
      out_sel   <= out_sel_n;
      if (ram_we)    wr_ptr <= wr_ptr + 1'b1;
      if (ram_rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // RAM write port; no reset so the array maps onto block RAM.
  always_ff @(posedge s_axis_aclk) begin
    if (ram_we) mem[wr_ptr] <= {s_axis.tlast, s_axis.tdata};
  end

  // RAM synchronous read register with enable, holding the beat while stalled.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) ram_q <= '0;
    else if (ram_rd_en) ram_q <= mem[rd_ptr];
  end

  // Bypass register for a beat arriving while the RAM holds nothing.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) byp_q <= '0;
    else if (byp_en) byp_q <= {s_axis.tlast, s_axis.tdata};
  end

  assign s_axis.tready   = ready_q;
  assign m_axis.tvalid   = out_valid;
  assign m_axis.tdata    = out_sel ? byp_q[DATA_WIDTH-1:0] : ram_q[DATA_WIDTH-1:0];
  assign m_axis.tlast    = out_sel ? byp_q[DATA_WIDTH]     : ram_q[DATA_WIDTH];
  assign axis_data_count = count;

endmodule

// File: tb/tb_axis_data_fifo.sv
// Directed self-checking bench for axis_data_fifo (DATA_WIDTH=64, DEPTH=1024).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axis_data_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] count;
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  axis_data_fifo_if #(.DATA_WIDTH(64)) s_if ();
  axis_data_fifo_if #(.DATA_WIDTH(64)) m_if ();

  axis_data_fifo #(.DATA_WIDTH(64), .DEPTH(1024)) dut (
    .s_axis_aclk    (clk),
    .s_axis_areset  (rst),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .axis_data_count(count)
  );

  task automatic test_reset;
    rst = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if ({m_if.tvalid, s_if.tready, count} !== 13'd0)
      $display("FAIL reset_state: tvalid=%b tready=%b count=%0d, want 0 0 0", m_if.tvalid, s_if.tready, count);
    else passed++;
    total++;
    if ({m_if.tlast, m_if.tdata} !== 65'd0)
      $display("FAIL reset_out_beat: got %b/%h, want 0/0", m_if.tlast, m_if.tdata);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_if.tready !== 1'b1)
      $display("FAIL reset_release_ready: got %b, want 1", s_if.tready);
    else passed++;
  endtask

  task automatic test_streaming;
    m_if.tready = 1'b1;
    for (int k = 1; k <= 2050; k++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 64'(k);
      s_if.tlast  = (k % 1024 == 0);
      @(negedge clk);
      total++;
      if ({m_if.tvalid, m_if.tlast, m_if.tdata, count} !== {1'b1, 1'(k % 1024 == 0), 64'(k), 11'd1})
        $display("FAIL stream_beat %0d: v=%b last=%b data=%0d cnt=%0d, want 1 %b %0d 1",
                 k, m_if.tvalid, m_if.tlast, m_if.tdata, count, (k % 1024 == 0), k);
      else passed++;
    end
    s_if.tvalid = 1'b0;
    @(negedge clk);
    total++;
    if ({m_if.tvalid, count} !== 12'd0)
      $display("FAIL stream_end_empty: v=%b cnt=%0d, want 0 0", m_if.tvalid, count);
    else passed++;
  endtask

  task automatic test_fill;
    int nxt = 1;
    int accepted = 0;
    logic rdy;
    m_if.tready = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      if (nxt <= 1100) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = 64'(nxt);
        s_if.tlast  = (nxt % 1024 == 0);
      end else begin
        s_if.tvalid = 1'b0;
      end
      rdy = s_if.tready;
      @(negedge clk);
      if (rdy && nxt <= 1100) begin
        accepted++;
        nxt++;
      end
      total++;
      if ({m_if.tvalid, m_if.tlast, m_if.tdata} !== {1'b1, 1'b0, 64'd1})
        $display("FAIL fill_hold cycle %0d: v=%b last=%b data=%0d, want 1 0 1", c, m_if.tvalid, m_if.tlast, m_if.tdata);
      else passed++;
    end
    s_if.tvalid = 1'b0;
    total++;
    if (accepted !== 1024) $display("FAIL fill_accepted: got %0d, want 1024", accepted);
    else passed++;
    total++;
    if ({s_if.tready, count} !== {1'b0, 11'd1024})
      $display("FAIL fill_full: tready=%b cnt=%0d, want 0 1024", s_if.tready, count);
    else passed++;
  endtask

  task automatic test_drain;
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b0;
    for (int j = 1; j <= 1024; j++) begin
      total++;
      if ({m_if.tvalid, m_if.tlast, m_if.tdata, count} !== {1'b1, 1'(j == 1024), 64'(j), 11'(1025 - j)})
        $display("FAIL drain_beat %0d: v=%b last=%b data=%0d cnt=%0d, want 1 %b %0d %0d",
                 j, m_if.tvalid, m_if.tlast, m_if.tdata, count, (j == 1024), j, 1025 - j);
      else passed++;
      @(negedge clk);
      if (j == 1) begin
        total++;
        if (s_if.tready !== 1'b1) $display("FAIL drain_ready_rise: got %b, want 1", s_if.tready);
        else passed++;
      end
    end
    total++;
    if ({m_if.tvalid, count} !== 12'd0)
      $display("FAIL drain_empty: v=%b cnt=%0d, want 0 0", m_if.tvalid, count);
    else passed++;
  endtask

  task automatic test_single_beat;
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 64'hDEADBEEF_00000001;
    s_if.tlast  = 1'b1;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = 64'h0;
    for (int h = 0; h < 4; h++) begin
      total++;
      if ({m_if.tvalid, m_if.tlast, m_if.tdata, count} !== {1'b1, 1'b1, 64'hDEADBEEF_00000001, 11'd1})
        $display("FAIL single_hold %0d: v=%b last=%b data=%h cnt=%0d, want 1 1 deadbeef00000001 1",
                 h, m_if.tvalid, m_if.tlast, m_if.tdata, count);
      else passed++;
      if (h < 3) @(negedge clk);
    end
    m_if.tready = 1'b1;
    @(negedge clk);
    total++;
    if ({m_if.tvalid, count} !== 12'd0)
      $display("FAIL single_taken: v=%b cnt=%0d, want 0 0", m_if.tvalid, count);
    else passed++;
  endtask

  task automatic test_back_to_back;
    m_if.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 64'(16 + i); s_if.tlast = 1'b0;
      @(negedge clk);
    end
    m_if.tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_if.tdata = 64'(19 + i);
      @(negedge clk);
      total++;
      if ({m_if.tvalid, m_if.tdata, count} !== {1'b1, 64'(17 + i), 11'd3})
        $display("FAIL b2b_steady %0d: v=%b data=%0d cnt=%0d, want 1 %0d 3", i, m_if.tvalid, m_if.tdata, count, 17 + i);
      else passed++;
    end
    s_if.tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (i < 2) begin
        if ({m_if.tvalid, m_if.tdata, count} !== {1'b1, 64'(25 + i), 11'(2 - i)})
          $display("FAIL b2b_tail %0d: v=%b data=%0d cnt=%0d, want 1 %0d %0d", i, m_if.tvalid, m_if.tdata, count, 25 + i, 2 - i);
        else passed++;
      end else begin
        if ({m_if.tvalid, count} !== 12'd0)
          $display("FAIL b2b_empty: v=%b cnt=%0d, want 0 0", m_if.tvalid, count);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid;
    m_if.tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 64'(256 + i); s_if.tlast = (i == 9);
      @(negedge clk);
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    total++;
    if (count !== 11'd10) $display("FAIL mid_count_before: got %0d, want 10", count);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({m_if.tvalid, s_if.tready, count, m_if.tdata} !== 77'd0)
      $display("FAIL mid_reset_state: v=%b rdy=%b cnt=%0d data=%h, want 0 0 0 0", m_if.tvalid, s_if.tready, count, m_if.tdata);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({s_if.tready, m_if.tvalid} !== 2'b10)
      $display("FAIL mid_restart: rdy=%b v=%b, want 1 0", s_if.tready, m_if.tvalid);
    else passed++;
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1; s_if.tdata = 64'hAAAA; s_if.tlast = 1'b0;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    total++;
    if ({m_if.tvalid, m_if.tlast, m_if.tdata} !== {1'b1, 1'b0, 64'hAAAA})
      $display("FAIL mid_new_beat: v=%b last=%b data=%h, want 1 0 aaaa", m_if.tvalid, m_if.tlast, m_if.tdata);
    else passed++;
    @(negedge clk);
    total++;
    if ({m_if.tvalid, count} !== 12'd0)
      $display("FAIL mid_no_stale: v=%b data=%h cnt=%0d, want 0 _ 0", m_if.tvalid, m_if.tdata, count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_fill();
    test_drain();
    test_single_beat();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
